// File: rtl/ddr_timing_model.sv
`default_nettype none
// ============================================================================
// Module   : ddr_timing_model
// Purpose  : Cycle-approximate DDR front end over a synchronous SRAM. Adds
//            calibration delay, per-bank open-row latencies and refresh blackouts.
// Revision : 1.0
// ============================================================================
module ddr_timing_model #(
    parameter int ABITS      = 29,
    parameter int DBITS      = 64,
    parameter int COL_BITS   = 13,
    parameter int BANK_BITS  = 3,
    parameter int CAL_CYCLES = 1000,
    parameter int TRCD       = 4,
    parameter int TCL        = 6,
    parameter int TRP        = 4,
    parameter int TREFI      = 7800,
    parameter int TRFC       = 260
) (
    input  logic                                 i_clk,
    input  logic                                 i_nrst,
    input  logic                                 i_req_valid,
    output logic                                 o_req_ready,
    input  logic [ABITS-1:0]                     i_req_addr,
    input  logic                                 i_req_write,
    input  logic [DBITS-1:0]                     i_req_wdata,
    input  logic [DBITS/8-1:0]                   i_req_wstrb,
    output logic                                 o_resp_valid,
    input  logic                                 i_resp_ready,
    output logic [DBITS-1:0]                     o_resp_rdata,
    output logic                                 o_mem_cs,
    output logic                                 o_mem_we,
    output logic [ABITS-$clog2(DBITS/8)-1:0]     o_mem_addr,
    output logic [DBITS-1:0]                     o_mem_wdata,
    output logic [DBITS/8-1:0]                   o_mem_wstrb,
    input  logic [DBITS-1:0]                     i_mem_rdata,
    output logic                                 o_init_calib_done,
    output logic                                 o_ref_active,
    output logic [31:0]                          o_stat_hits,
    output logic [31:0]                          o_stat_misses
);

    localparam int c_OFF   = $clog2(DBITS/8);
    localparam int c_WBITS = ABITS - c_OFF;
    localparam int c_NBANK = 1 << BANK_BITS;
    localparam int c_RBITS = ABITS - COL_BITS - BANK_BITS;

    // Wait counters are loaded with W-1 so WAIT lasts exactly W cycles.
    localparam logic [31:0] c_W_HIT    = 32'(TCL - 1);
    localparam logic [31:0] c_W_CLOSED = 32'(TRCD + TCL - 1);
    localparam logic [31:0] c_W_CONFL  = 32'(TRP + TRCD + TCL - 1);
    localparam logic [31:0] c_CAL_LAST = 32'(CAL_CYCLES - 1);
    localparam logic [31:0] c_REFI_LAST = 32'(TREFI - 1);
    localparam logic [31:0] c_RFC_LAST = 32'(TRFC - 1);

    typedef enum logic [2:0] {
        S_CALIB   = 3'd0,
        S_IDLE    = 3'd1,
        S_WAIT    = 3'd2,
        S_MEM     = 3'd3,
        S_CAPT    = 3'd4,
        S_RESP    = 3'd5,
        S_REFRESH = 3'd6
    } state_t;

    state_t                 r_state;
    logic [31:0]            r_cnt;
    logic [31:0]            r_ref_cnt;
    logic                   r_ref_pending;
    logic                   r_calib_done;
    logic [c_NBANK-1:0]     r_open_valid;
    logic [c_RBITS-1:0]     r_open_row [c_NBANK];
    logic                   r_we;
    logic [c_WBITS-1:0]     r_addr;
    logic [DBITS-1:0]       r_wdata;
    logic [DBITS/8-1:0]     r_wstrb;
    logic [DBITS-1:0]       r_rdata;
    logic [31:0]            r_hits;
    logic [31:0]            r_misses;

    logic [BANK_BITS-1:0]   w_bank;
    logic [c_RBITS-1:0]     w_row;
    logic                   w_open;
    logic                   w_hit;
    logic                   w_unused;

    assign w_bank   = i_req_addr[COL_BITS+BANK_BITS-1:COL_BITS];
    assign w_row    = i_req_addr[ABITS-1:COL_BITS+BANK_BITS];
    assign w_open   = r_open_valid[w_bank];
    assign w_hit    = w_open && (r_open_row[w_bank] == w_row);
    assign w_unused = ^i_req_addr[c_OFF-1:0];

    assign o_req_ready       = (r_state == S_IDLE) && !r_ref_pending;
    assign o_resp_valid      = (r_state == S_RESP);
    assign o_mem_cs          = (r_state == S_MEM);
    assign o_ref_active      = (r_state == S_REFRESH);
    assign o_resp_rdata      = r_rdata;
    assign o_mem_we          = r_we;
    assign o_mem_addr        = r_addr;
    assign o_mem_wdata       = r_wdata;
    assign o_mem_wstrb       = r_wstrb;
    assign o_init_calib_done = r_calib_done;
    assign o_stat_hits       = r_hits;
    assign o_stat_misses     = r_misses;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state       <= S_CALIB;
            r_cnt         <= '0;
            r_ref_cnt     <= '0;
            r_ref_pending <= 1'b0;
            r_calib_done  <= 1'b0;
            r_open_valid  <= '0;
            for (int b = 0; b < c_NBANK; b++) begin
                r_open_row[b] <= '0;
            end
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_rdata       <= '0;
            r_hits        <= '0;
            r_misses      <= '0;
        end else begin
            if (r_calib_done) begin
                r_ref_cnt <= (r_ref_cnt == c_REFI_LAST) ? '0 : r_ref_cnt + 32'd1;
            end

            case (r_state)
                S_CALIB: begin
                    if (r_cnt == c_CAL_LAST) begin
                        r_cnt        <= '0;
                        r_calib_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_IDLE: begin
                    if (r_ref_pending) begin
                        r_ref_pending <= 1'b0;
                        r_open_valid  <= '0;
                        r_cnt         <= '0;
                        r_state       <= S_REFRESH;
                    end else if (i_req_valid) begin
                        r_we    <= i_req_write;
                        r_addr  <= i_req_addr[ABITS-1:c_OFF];
                        r_wdata <= i_req_wdata;
                        r_wstrb <= i_req_wstrb;
                        if (w_hit) begin
                            r_cnt  <= c_W_HIT;
                            r_hits <= r_hits + 32'd1;
                        end else begin
                            r_cnt    <= w_open ? c_W_CONFL : c_W_CLOSED;
                            r_misses <= r_misses + 32'd1;
                        end
                        r_open_row[w_bank]   <= w_row;
                        r_open_valid[w_bank] <= 1'b1;
                        r_state              <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_MEM;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_MEM: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_rdata <= r_we ? '0 : i_mem_rdata;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_REFRESH: begin
                    if (r_cnt == c_RFC_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= S_CALIB;
                end
            endcase

            // A timer expiry on the refresh-entry edge must not be lost.
            if (r_calib_done && (r_ref_cnt == c_REFI_LAST)) begin
                r_ref_pending <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_timing_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_timing_model
// Purpose  : Randomized self-checking bench for ddr_timing_model against a
//            timeline-based behavioural reference model.
// Revision : 1.0
// ============================================================================
module tb_ddr_timing_model;

    localparam int ABITS = 29;
    localparam int DBITS = 64;
    localparam int CAL   = 16;
    localparam int TRCD  = 3;
    localparam int TCL   = 4;
    localparam int TRP   = 2;
    localparam int TREFI = 200;
    localparam int TRFC  = 10;
    localparam int MEMW  = 16384;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [28:0] i_req_addr;
    logic        i_req_write;
    logic [63:0] i_req_wdata;
    logic [7:0]  i_req_wstrb;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [63:0] o_resp_rdata;
    logic        o_mem_cs;
    logic        o_mem_we;
    logic [25:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wstrb;
    logic [63:0] i_mem_rdata;
    logic        o_init_calib_done;
    logic        o_ref_active;
    logic [31:0] o_stat_hits;
    logic [31:0] o_stat_misses;

    int n_checks = 0;
    int n_errors = 0;
    int m_cyc    = 0;

    always #5 i_clk = ~i_clk;

    ddr_timing_model #(
        .ABITS(ABITS), .DBITS(DBITS), .COL_BITS(13), .BANK_BITS(3),
        .CAL_CYCLES(CAL), .TRCD(TRCD), .TCL(TCL), .TRP(TRP),
        .TREFI(TREFI), .TRFC(TRFC)
    ) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_write(i_req_write),
        .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_rdata(o_resp_rdata),
        .o_mem_cs(o_mem_cs), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_rdata(i_mem_rdata),
        .o_init_calib_done(o_init_calib_done), .o_ref_active(o_ref_active),
        .o_stat_hits(o_stat_hits), .o_stat_misses(o_stat_misses)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Backing SRAM: read-before-write, data returned the cycle after the strobe.
    initial begin : sram_proc
        logic [63:0] sram [MEMW];
        logic [63:0] cur;
        int          idx;
        for (int i = 0; i < MEMW; i++) sram[i] = '0;
        i_mem_rdata <= '0;
        forever begin
            @(posedge i_clk);
            if (o_mem_cs) begin
                idx = int'(o_mem_addr[13:0]);
                cur = sram[idx];
                i_mem_rdata <= cur;
                if (o_mem_we) begin
                    for (int b = 0; b < 8; b++)
                        if (o_mem_wstrb[b]) cur[8*b +: 8] = o_mem_wdata[8*b +: 8];
                    sram[idx] = cur;
                end
            end
        end
    end

    // Reference model: tracks absolute response/refresh times per transaction.
    initial begin : model_proc
        logic [63:0] shadow [MEMW];
        logic [7:0]  m_ov;
        int          m_orow [8];
        int          m_busy;      // 0 idle, 1 transaction, 2 refresh
        logic        m_pend;
        int          m_resp_at, m_mem_at, m_ref_end;
        int          m_hits, m_miss;
        logic        m_we;
        int          m_word;
        logic [63:0] m_wdata, m_rd, v;
        logic [7:0]  m_wstrb;
        int          c, bank, row, w;
        logic        done, e_ready, e_resp, e_cs, due, enter;
        for (int i = 0; i < MEMW; i++) shadow[i] = '0;
        m_ov = '0; m_busy = 0; m_pend = 1'b0; m_hits = 0; m_miss = 0;
        m_resp_at = 0; m_mem_at = 0; m_ref_end = 0; m_we = 1'b0; m_word = 0;
        m_wdata = '0; m_wstrb = '0; m_rd = '0;
        for (int b = 0; b < 8; b++) m_orow[b] = 0;
        forever begin
            @(negedge i_clk);
            if (!i_nrst) begin
                chk("rst_req_ready",  64'(o_req_ready), 64'(0));
                chk("rst_resp_valid", 64'(o_resp_valid), 64'(0));
                chk("rst_resp_rdata", o_resp_rdata, 64'(0));
                chk("rst_mem_cs",     64'(o_mem_cs), 64'(0));
                chk("rst_mem_fields", 64'({o_mem_we, o_mem_addr, o_mem_wstrb}), 64'(0));
                chk("rst_mem_wdata",  o_mem_wdata, 64'(0));
                chk("rst_calib_done", 64'(o_init_calib_done), 64'(0));
                chk("rst_ref_active", 64'(o_ref_active), 64'(0));
                chk("rst_stat_hits",  64'(o_stat_hits), 64'(0));
                chk("rst_stat_misses", 64'(o_stat_misses), 64'(0));
                m_ov = '0; m_busy = 0; m_pend = 1'b0; m_hits = 0; m_miss = 0;
                m_cyc = 0;
            end else begin
                c       = m_cyc;
                done    = (c >= CAL);
                e_ready = done && (m_busy == 0) && !m_pend;
                e_resp  = (m_busy == 1) && (c >= m_resp_at);
                e_cs    = (m_busy == 1) && (c == m_mem_at);
                chk("req_ready",  64'(o_req_ready), 64'(e_ready));
                chk("calib_done", 64'(o_init_calib_done), 64'(done));
                chk("ref_active", 64'(o_ref_active), 64'(m_busy == 2));
                chk("resp_valid", 64'(o_resp_valid), 64'(e_resp));
                chk("mem_cs",     64'(o_mem_cs), 64'(e_cs));
                chk("stat_hits",  64'(o_stat_hits), 64'(m_hits));
                chk("stat_misses", 64'(o_stat_misses), 64'(m_miss));
                if (e_resp) chk("resp_rdata", o_resp_rdata, m_rd);
                if (e_cs) begin
                    chk("mem_we",    64'(o_mem_we), 64'(m_we));
                    chk("mem_addr",  64'(o_mem_addr), 64'(m_word));
                    chk("mem_wdata", o_mem_wdata, m_wdata);
                    chk("mem_wstrb", 64'(o_mem_wstrb), 64'(m_wstrb));
                end

                due   = ((c + 1) > CAL) && (((c + 1 - CAL) % TREFI) == 0);
                enter = 1'b0;
                if (m_busy == 0) begin
                    if (done && m_pend) begin
                        m_busy = 2; m_ref_end = c + TRFC; enter = 1'b1; m_ov = '0;
                    end else if (e_ready && i_req_valid) begin
                        bank = (int'(i_req_addr) >> 13) & 7;
                        row  = int'(i_req_addr) >> 16;
                        if (m_ov[bank] && m_orow[bank] == row) begin
                            w = TCL; m_hits++;
                        end else if (!m_ov[bank]) begin
                            w = TRCD + TCL; m_miss++;
                        end else begin
                            w = TRP + TRCD + TCL; m_miss++;
                        end
                        m_ov[bank] = 1'b1; m_orow[bank] = row;
                        m_mem_at  = c + w + 1;
                        m_resp_at = c + w + 3;
                        m_busy    = 1;
                        m_we      = i_req_write;
                        m_word    = int'(i_req_addr) >> 3;
                        m_wdata   = i_req_wdata;
                        m_wstrb   = i_req_wstrb;
                        v = shadow[m_word % MEMW];
                        if (i_req_write) begin
                            for (int b = 0; b < 8; b++)
                                if (i_req_wstrb[b]) v[8*b +: 8] = i_req_wdata[8*b +: 8];
                            shadow[m_word % MEMW] = v;
                            m_rd = '0;
                        end else begin
                            m_rd = v;
                        end
                    end
                end else if (m_busy == 1) begin
                    if (e_resp && i_resp_ready) m_busy = 0;
                end else if (c == m_ref_end) begin
                    m_busy = 0;
                end
                m_pend = (m_pend && !enter) || due;
                m_cyc  = c + 1;
            end
        end
    end

    // Issues one request from posedge+1 and returns at posedge+1 after the response is taken.
    task automatic do_txn(input logic wr, input logic [28:0] addr, input logic [63:0] wd,
                          input logic [7:0] ws, input int hold,
                          output int wait_c, output int lat, output logic [63:0] rd);
        logic got;
        i_resp_ready = (hold == 0);
        i_req_write  = wr;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        i_req_wstrb  = ws;
        i_req_valid  = 1'b1;
        wait_c = 0; got = 1'b0;
        while (!got && wait_c < 2000) begin
            @(negedge i_clk);
            if (o_req_ready) got = 1'b1; else wait_c++;
        end
        chk("req_accept_timeout", 64'(got), 64'(1));
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge i_clk);
            lat++;
            if (o_resp_valid) got = 1'b1;
        end
        chk("resp_timeout", 64'(got), 64'(1));
        rd = o_resp_rdata;
        if (hold > 0) begin
            repeat (hold) @(posedge i_clk);
            #1 i_resp_ready = 1'b1;
        end
        @(posedge i_clk); #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run did not complete, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          wc, lat, n, hold, gap;
        logic [63:0] rd;
        int          rb, rr, rc;
        i_nrst = 1'b0; i_req_valid = 1'b0; i_req_addr = '0; i_req_write = 1'b0;
        i_req_wdata = '0; i_req_wstrb = '0; i_resp_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_nrst = 1'b1;

        // Valid held from reset release; first access is to a closed row.
        do_txn(1'b0, 29'h2000, 64'h0, 8'h00, 0, wc, lat, rd);
        chk("calib_wait_cycles", 64'(wc), 64'(16));
        chk("closed_read_latency", 64'(lat), 64'(10));
        chk("first_misses", 64'(o_stat_misses), 64'(1));

        do_txn(1'b1, 29'h1000, 64'h1122334455667788, 8'hFF, 0, wc, lat, rd);
        chk("write_latency", 64'(lat), 64'(10));
        chk("write_resp_rdata", rd, 64'h0);
        do_txn(1'b0, 29'h1008, 64'h0, 8'h00, 0, wc, lat, rd);
        chk("hit_latency", 64'(lat), 64'(7));
        chk("back_to_back_wait", 64'(wc), 64'(0));
        do_txn(1'b0, 29'h1000, 64'h0, 8'h00, 0, wc, lat, rd);
        chk("hit_rdata", rd, 64'h1122334455667788);
        chk("hits_after_two", 64'(o_stat_hits), 64'(2));
        do_txn(1'b0, 29'h11000, 64'h0, 8'h00, 0, wc, lat, rd);
        chk("conflict_latency", 64'(lat), 64'(12));
        chk("misses_after_conflict", 64'(o_stat_misses), 64'(3));

        // Idle through the first refresh, then touch a row that was open before it.
        n = 0;
        while (!o_ref_active && n < 400) begin @(negedge i_clk); n++; end
        n = 0;
        while (o_ref_active && n < 50) begin @(negedge i_clk); n++; end
        chk("refresh_duration", 64'(n), 64'(10));
        @(posedge i_clk); #1;
        do_txn(1'b0, 29'h11000, 64'h0, 8'h00, 0, wc, lat, rd);
        chk("post_refresh_latency", 64'(lat), 64'(10));

        // Stall the response across a refresh expiry.
        n = 0;
        while (((m_cyc - CAL) % TREFI) != (TREFI - 15) && n < 400) begin
            @(posedge i_clk); #1; n++;
        end
        do_txn(1'b0, 29'h1000, 64'h0, 8'h00, 20, wc, lat, rd);
        chk("held_resp_rdata", rd, 64'h1122334455667788);
        n = 0;
        while (!o_ref_active && n < 10) begin @(negedge i_clk); n++; end
        chk("deferred_refresh_start", 64'(n), 64'(2));
        n = 0;
        while (o_ref_active && n < 50) begin @(negedge i_clk); n++; end
        @(posedge i_clk); #1;

        for (int t = 0; t < 40; t++) begin
            rb = $urandom_range(0, 2);
            rr = $urandom_range(0, 1);
            rc = $urandom_range(0, 3);
            hold = $urandom_range(0, 3);
            gap  = $urandom_range(0, 2);
            do_txn(1'($urandom_range(0, 1)), 29'((rr << 16) | (rb << 13) | (rc << 3)),
                   {$urandom, $urandom}, 8'($urandom_range(0, 255)), hold, wc, lat, rd);
            repeat (gap) begin @(posedge i_clk); #1; end
        end

        // Asynchronous reset while the request is waiting on DRAM timing.
        i_resp_ready = 1'b1; i_req_write = 1'b0; i_req_addr = 29'h2000; i_req_valid = 1'b1;
        n = 0;
        do begin @(negedge i_clk); n++; end while (!o_req_ready && n < 500);
        @(posedge i_clk); #1 i_req_valid = 1'b0;
        @(posedge i_clk); #1 i_nrst = 1'b0;
        @(negedge i_clk);
        chk("reset_in_wait_calib", 64'(o_init_calib_done), 64'(0));
        chk("reset_in_wait_hits", 64'(o_stat_hits), 64'(0));
        chk("reset_in_wait_misses", 64'(o_stat_misses), 64'(0));
        @(posedge i_clk); @(posedge i_clk); #1 i_nrst = 1'b1;

        do_txn(1'b0, 29'h2000, 64'h0, 8'h00, 0, wc, lat, rd);
        chk("recal_wait_cycles", 64'(wc), 64'(16));
        chk("recal_read_latency", 64'(lat), 64'(10));
        chk("recal_misses", 64'(o_stat_misses), 64'(1));
        chk("recal_hits", 64'(o_stat_hits), 64'(0));

        repeat (5) @(posedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr_timing_model.md
Name: ddr_timing_model

Overview:
Cycle-approximate DDR functional model with parametrised width and bank/row geometry. It replaces the zero-latency, always-calibrated behaviour of the current simulation DDR stub. It sits between the AXI-to-request adapter and a backing synchronous SRAM, and adds calibration delay, per-bank open-row tracking (hit/closed/conflict latencies) and periodic refresh blackouts. It exposes calibration status and hit/miss statistics for the APB DDR control registers.

Parameters:
abits, 29, byte address width
dbits, 64, data width (power of 2, ≥16)
col_bits, 13, byte-address bits below bank field
bank_bits, 3, bank select bits (2**bank_bits banks)
CAL_CYCLES, 1000, cycles from reset release to calibration done (≥1)
TRCD, 4, activate-to-CAS cycles (≥1)
TCL, 6, CAS latency cycles (≥1)
TRP, 4, precharge cycles (≥1)
TREFI, 7800, refresh interval cycles (> TRFC)
TRFC, 260, refresh duration cycles (≥1)

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted when valid&ready
i_req_addr  in  abits  byte address
i_req_write  in  1  1=write, 0=read
i_req_wdata  in  dbits  write data
i_req_wstrb  in  dbits/8  byte enables
o_resp_valid  out  1  response valid
i_resp_ready  in  1  response consumed
o_resp_rdata  out  dbits  read data (0 for writes)
o_mem_cs  out  1  SRAM access strobe (1 cycle)
o_mem_we  out  1  SRAM write enable
o_mem_addr  out  abits-log2(dbits/8)  SRAM word address
o_mem_wdata  out  dbits  SRAM write data
o_mem_wstrb  out  dbits/8  SRAM byte enables
i_mem_rdata  in  dbits  SRAM read data, valid the cycle after o_mem_cs
o_init_calib_done  out  1  calibration complete
o_ref_active  out  1  refresh in progress
o_stat_hits  out  32  row-hit counter
o_stat_misses  out  32  row-closed + row-conflict counter

Behaviour:
- Reset (async, any state): state=CALIB; all outputs 0; counters, open_valid[] and ref_pending cleared.
- Address decode: bank = addr[col_bits+bank_bits-1:col_bits]; row = addr[abits-1:col_bits+bank_bits]; word = addr[abits-1:log2(dbits/8)].
- CALIB: counts 0..CAL_CYCLES-1, then o_init_calib_done=1 (sticky until reset) → IDLE. o_req_ready=0 throughout.
- Refresh timer starts on leaving CALIB; after TREFI cycles it sets ref_pending and restarts. A second expiry while ref_pending is still set is absorbed (single pending, no queueing).
- IDLE: o_req_ready = ~ref_pending. ref_pending has priority → REFRESH. Otherwise, on handshake the block latches the request and classifies it:
  - hit (open_valid[bank] and open_row[bank]==row): wait W=TCL
  - closed (~open_valid[bank]): W=TRCD+TCL
  - conflict (open with a different row): W=TRP+TRCD+TCL
  - After classification: open_row[bank]=row, open_valid[bank]=1. Hit increments o_stat_hits; closed or conflict increments o_stat_misses. Both counters wrap at 2**32.
- WAIT: W cycles → MEM.
- MEM: exactly 1 cycle with o_mem_cs=1 and o_mem_we/addr/wdata/wstrb from the latched request → CAPT.
- CAPT: register i_mem_rdata (registers 0 for writes) → RESP.
- RESP: o_resp_valid=1, o_resp_rdata held stable until i_resp_ready; then → IDLE.
- Latency: handshake in cycle 0 → o_resp_valid first high in cycle W+3.
- Back-to-back: a new request is not accepted in the cycle the response is consumed; the earliest next handshake is the following cycle (IDLE).
- REFRESH: o_ref_active=1 for TRFC cycles. On entry, clears ref_pending and all open_valid[]. → IDLE.
- A refresh that becomes due mid-transaction is serviced only on the next return to IDLE, before any new request.

Test Plan:
(CAL_CYCLES=16, TRCD=3, TCL=4, TRP=2, TREFI=200, TRFC=10, dbits=64)
- Reset release, i_req_valid held high -> o_req_ready=0 and o_init_calib_done=0 for 16 cycles; both rise the cycle after; first read (closed row) -> o_resp_valid at cycle 10 after handshake, o_stat_misses=1.
- Write 0x1122334455667788 wstrb=0xFF to 0x1000, then read 0x1008 (same bank/row) -> read is a hit, o_resp_valid at cycle 7, rdata=SRAM content, o_stat_hits=1; write response rdata=0.
- Read 0x1000 then read 0x1000+(1<<16) (same bank, different row) -> second response at cycle 12, o_stat_misses increments.
- Idle until refresh due -> o_ref_active high exactly 10 cycles, o_req_ready=0 during it; next access to a previously open row is classified closed (10-cycle latency).
- Hold i_resp_ready=0 for 20 cycles -> o_resp_valid and o_resp_rdata stable; o_req_ready stays 0; an expired refresh waits and runs right after the response handshake.
- Assert i_nrst=0 during WAIT -> all outputs 0 immediately; after release the block re-enters CALIB and the counters read 0.
